can_tx_bit_stuffer: RTL
=======================

// Module: can_tx_bit_stuffer
// PURPOSE
//  Sits between the CAN frame transmitter and the bus driver. Forwards the transmitter's
//  serial bit one bit time later and inserts a complement stuff bit after STUFF_LEN
//  identical bits in the stuffed region (SOF..CRC). Throttles the transmitter during stuff
//  bits and checks the bus readback for arbitration loss and bit errors.
// PARAMETERS
//  STUFF_LEN   5   identical consecutive bits that trigger a stuff bit (legal range 2..7)
// PORTS
//  clk                input   1  system clock; single clock domain
//  rst                input   1  asynchronous, active-high reset
//  sample_point       input   1  one-cycle strobe, one per bit time
//  frame_active       input   1  controller: frame transmission in progress
//  tx_bit_in          input   1  transmitter serial bit for the current bit time
//  stuff_en           input   1  tx_bit_in lies in SOF..last CRC bit
//  arb_field          input   1  tx_bit_in lies in the arbitration field
//  ack_slot           input   1  tx_bit_in is the ACK slot bit
//  rx_bit             input   1  bus level sampled at this sample_point
//  tx_advance         output  1  gated sample_point to the transmitter
//  can_tx             output  1  registered bus drive; 0 = dominant
//  stuff_bit_active   output  1  can_tx currently carries a stuff bit
//  arb_lost           output  1  one-cycle pulse: arbitration lost
//  bit_error          output  1  one-cycle pulse: readback mismatch
// BEHAVIOUR
//  Reset (asynchronous):
//   - can_tx=1; tx_advance, stuff_bit_active, arb_lost and bit_error = 0.
//   - run_cnt=0, state=IDLE; all sideband flops cleared.
//  tx_advance = sample_point & ~stuff_due (combinational). Transmitter holds its bit while low.
//  stuff_due = (state==ACTIVE) & region_ff & (run_cnt==STUFF_LEN).
//  Every update below occurs only on sample_point; all flops hold otherwise.
//  States:
//   - IDLE: can_tx<=1. When frame_active=1: ->ACTIVE and forward tx_bit_in (SOF). run_cnt<=1.
//   - ACTIVE, stuff_due=0:
//     - Forward: can_tx<=tx_bit_in. Latch region_ff, arb_ff and ack_ff from the sidebands.
//     - Run count: run_cnt<=(tx_bit_in==can_tx && stuff_en) ? run_cnt+1 : 1.
//   - ACTIVE, stuff_due=1: can_tx<=~can_tx, stuff_bit_active<=1, run_cnt<=1 -> STUFF.
//     - The stuff bit starts a new run of its own polarity.
//     - A stuff bit after the final CRC bit is inserted (region_ff still 1).
//   - STUFF: forward the held tx_bit_in exactly as in ACTIVE, clear stuff_bit_active -> ACTIVE.
//     - Two stuff bits in a row are never possible.
//   - LOST: can_tx<=1 (recessive) and no checks. When frame_active=0 -> IDLE.
//  Readback check (ACTIVE/STUFF, each sample_point, before the update):
//   - Case a: mismatch, can_tx=1, rx_bit=0, arb_ff=1 and not a stuff bit:
//     - arb_lost=1 for one cycle; ->LOST; can_tx<=1.
//   - Case b: any other mismatch, except can_tx=1 with ack_ff=1 (ACK slot):
//     - bit_error=1 for one cycle; keep driving. The controller reacts.
//   - Case c: a mismatch on a stuff bit is always a bit_error, even inside arbitration.
//  frame_active=0 in ACTIVE/STUFF: ->IDLE; can_tx<=1; run_cnt<=0; a pending stuff bit is dropped.
//  sample_point=0: all state holds; tx_advance=0.
//  Latency:
//   - Each transmitter bit appears on can_tx one bit time after it is presented.
//   - Each stuff bit adds one bit time.
//  run_cnt is 3 bits, saturates at 7 and never wraps.
// STRUCTURE
//  Shared package (can_defs.svh):
//   - CAN_DOMINANT=1'b0 and CAN_RECESSIVE=1'b1.
//   - CAN_STUFF_LEN=5 (default source for STUFF_LEN).
//   - typedef enum logic[1:0] {STF_IDLE, STF_ACTIVE, STF_STUFF, STF_LOST} stuff_state_t.
//  No sub-module: one FSM, one run counter, three sideband flops.
//  The controller wires tx_advance into the transmitter's sample_point input.
// TESTING
//  1. Drive tx_bit_in=0 for 6 bits with stuff_en=1:
//     - can_tx reads 0,0,0,0,0, then stuff 1, then 0.
//     - tx_advance is low exactly in the stuff cycle; stuff_bit_active pulses once.
//  2. Drive 5x1 then 4x0, stuff_en=1:
//     - can_tx reads 11111 0(stuff) 0000.
//     - No second stuff bit: the stuff bit counts toward the 0-run (1+4=5), so the check
//       comes on the next bit.
//  3. Last 5 CRC bits are 0, then stuff_en falls:
//     - A stuff 1 still precedes the delimiter.
//     - The delimiter follows unstuffed; run_cnt is not incremented afterwards.
//  4. In arb_field, can_tx=1 while rx_bit=0 on ID bit 3:
//     - One-cycle arb_lost pulse, then can_tx=1 until frame_active=0, then IDLE.
//     - No bit_error is raised.
//  5. Mismatches outside arbitration:
//     - can_tx=0 with rx_bit=1 in the DLC -> bit_error pulse.
//     - can_tx=1 with rx_bit=0 in the ACK slot -> no error.
//  6. Reset mid-frame (rst high during STUFF):
//     - Immediately can_tx=1 and all pulses 0.
//     - After release with frame_active=1, the next SOF is forwarded with run_cnt=1.

Source files
------------

// File: rtl/can_tx_bit_stuffer_pkg.sv
// Shared CAN bus levels, default stuffing length and the stuffer FSM state type.
package can_tx_bit_stuffer_pkg;

   localparam logic CAN_DOMINANT  = 1'b0;
   localparam logic CAN_RECESSIVE = 1'b1;

   localparam int CAN_STUFF_LEN = 5;

   typedef enum logic [1:0] {
      STF_IDLE,
      STF_ACTIVE,
      STF_STUFF,
      STF_LOST
   } stuff_state_t;

endpackage

// File: rtl/can_tx_bit_stuffer.sv
// CAN transmit bit stuffer: forwards the transmitter bit one bit time later, inserts
// complement stuff bits in SOF..CRC and checks bus readback for arbitration loss / bit errors.
module can_tx_bit_stuffer
   import can_tx_bit_stuffer_pkg::*;
#(
   parameter int STUFF_LEN = CAN_STUFF_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_point,
   input  logic frame_active,
   input  logic tx_bit_in,
   input  logic stuff_en,
   input  logic arb_field,
   input  logic ack_slot,
   input  logic rx_bit,
   output logic tx_advance,
   output logic can_tx,
   output logic stuff_bit_active,
   output logic arb_lost,
   output logic bit_error
);

   localparam logic [2:0] LP_STUFF_LEN = 3'(STUFF_LEN);

   stuff_state_t r_state;
   logic [2:0]   r_run_cnt;
   logic         r_region;
   logic         r_arb;
   logic         r_ack;
   logic         r_can_tx;
   logic         r_stuff_active;
   logic         r_arb_lost;
   logic         r_bit_error;

   logic         w_stuff_due;
   logic         w_checking;
   logic         w_mismatch;
   logic         w_lose_arb;
   logic         w_bit_err;
   logic [2:0]   w_next_run;

   function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
      return (cnt == 3'd7) ? cnt : cnt + 3'd1;
   endfunction

   assign w_stuff_due = (r_state == STF_ACTIVE) && r_region && (r_run_cnt == LP_STUFF_LEN);
   assign tx_advance  = sample_point && !w_stuff_due;

   // Readback compares the level we drove last bit time with what the bus returned now.
   assign w_checking = ((r_state == STF_ACTIVE) || (r_state == STF_STUFF)) && frame_active;
   assign w_mismatch = w_checking && (rx_bit != r_can_tx);
   assign w_lose_arb = w_mismatch && (r_can_tx == CAN_RECESSIVE) && r_arb
                       && (r_state != STF_STUFF);
   assign w_bit_err  = w_mismatch && !w_lose_arb
                       && ((r_state == STF_STUFF) || !((r_can_tx == CAN_RECESSIVE) && r_ack));

   assign w_next_run = ((tx_bit_in == r_can_tx) && stuff_en) ? sat_inc(r_run_cnt) : 3'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= STF_IDLE;
         r_can_tx       <= CAN_RECESSIVE;
         r_run_cnt      <= 3'd0;
         r_region       <= 1'b0;
         r_arb          <= 1'b0;
         r_ack          <= 1'b0;
         r_stuff_active <= 1'b0;
         r_arb_lost     <= 1'b0;
         r_bit_error    <= 1'b0;
      end else begin
         r_arb_lost  <= 1'b0;
         r_bit_error <= 1'b0;
         if (sample_point) begin
            r_arb_lost  <= w_lose_arb;
            r_bit_error <= w_bit_err;
            case (r_state)
               STF_IDLE: begin
                  r_can_tx <= CAN_RECESSIVE;
                  if (frame_active) begin
                     r_state   <= STF_ACTIVE;
                     r_can_tx  <= tx_bit_in;
                     r_run_cnt <= 3'd1;
                     r_region  <= stuff_en;
                     r_arb     <= arb_field;
                     r_ack     <= ack_slot;
                  end
               end
               STF_ACTIVE, STF_STUFF: begin
                  if (!frame_active) begin
                     r_state        <= STF_IDLE;
                     r_can_tx       <= CAN_RECESSIVE;
                     r_run_cnt      <= 3'd0;
                     r_region       <= 1'b0;
                     r_arb          <= 1'b0;
                     r_ack          <= 1'b0;
                     r_stuff_active <= 1'b0;
                  end else if (w_lose_arb) begin
                     r_state        <= STF_LOST;
                     r_can_tx       <= CAN_RECESSIVE;
                     r_stuff_active <= 1'b0;
                  end else if (w_stuff_due) begin
                     // Transmitter is held this bit time; the stuff bit opens a new run.
                     r_state        <= STF_STUFF;
                     r_can_tx       <= !r_can_tx;
                     r_stuff_active <= 1'b1;
                     r_run_cnt      <= 3'd1;
                  end else begin
                     r_state        <= STF_ACTIVE;
                     r_can_tx       <= tx_bit_in;
                     r_run_cnt      <= w_next_run;
                     r_region       <= stuff_en;
                     r_arb          <= arb_field;
                     r_ack          <= ack_slot;
                     r_stuff_active <= 1'b0;
                  end
               end
               STF_LOST: begin
                  r_can_tx <= CAN_RECESSIVE;
                  if (!frame_active) begin
                     r_state   <= STF_IDLE;
                     r_run_cnt <= 3'd0;
                     r_region  <= 1'b0;
                     r_arb     <= 1'b0;
                     r_ack     <= 1'b0;
                  end
               end
               default: begin
                  r_state  <= STF_IDLE;
                  r_can_tx <= CAN_RECESSIVE;
               end
            endcase
         end
      end
   end

   assign can_tx           = r_can_tx;
   assign stuff_bit_active = r_stuff_active;
   assign arb_lost         = r_arb_lost;
   assign bit_error        = r_bit_error;

endmodule
